vga_pattern_source: RTL and testbench

VGA_PATTERN_SOURCE -- requirements
Module: vga_pattern_source

---
 rtl/vga_pattern_source_pkg.sv | 53 +++++
 rtl/vga_timing_counter.sv | 62 ++++++
 rtl/vga_pattern_source.sv | 157 +++++++++++++++
 tb/tb_vga_pattern_source.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_source_pkg.sv
// vga_pattern_source_pkg
//   Shared definitions for the VGA pattern source and its timing counter:
//   default 640x480@60 timing constants, pattern_sel encodings, the
//   per-axis phase states and the colour-bar lookup.
//   No ports (package).
package vga_pattern_source_pkg;

   localparam int C_DEF_COMPONENT_DEPTH = 8;

   localparam int C_DEF_H_ACTIVE = 640;
   localparam int C_DEF_H_FRONT  = 16;
   localparam int C_DEF_H_SYNC   = 96;
   localparam int C_DEF_H_BACK   = 48;

   localparam int C_DEF_V_ACTIVE = 480;
   localparam int C_DEF_V_FRONT  = 10;
   localparam int C_DEF_V_SYNC   = 2;
   localparam int C_DEF_V_BACK   = 33;

   // pattern_sel encodings
   typedef enum logic [1:0] {
      PAT_BARS    = 2'd0,
      PAT_RAMP    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_BLACK   = 2'd3
   } pattern_t;

   // Phase of one timing axis within its period
   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   // Colour bar {r,g,b} on/off flags: white, yellow, cyan, green,
   // magenta, red, blue, black.
   function automatic logic [2:0] bar_colour(input logic [2:0] idx);
      logic [2:0] rgb;
      case (idx)
         3'd0:    rgb = 3'b111;
         3'd1:    rgb = 3'b110;
         3'd2:    rgb = 3'b011;
         3'd3:    rgb = 3'b010;
         3'd4:    rgb = 3'b101;
         3'd5:    rgb = 3'b100;
         3'd6:    rgb = 3'b001;
         default: rgb = 3'b000;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter
//   One timing axis: a position counter running 0..TOTAL-1 and a phase FSM
//   (ACTIVE, FRONT, SYNC, BACK) that tracks which period the counter is in.
//   Ports:
//     clk    in   clock
//     rst    in   synchronous active-high reset (count 0, phase ACTIVE)
//     step   in   advance one position this cycle
//     count  out  current position
//     active out  position lies in the active period
//     sync   out  position lies in the sync period
module vga_timing_counter
   import vga_pattern_source_pkg::*;
#(
   parameter int C_ACTIVE = C_DEF_H_ACTIVE,
   parameter int C_FRONT  = C_DEF_H_FRONT,
   parameter int C_SYNC   = C_DEF_H_SYNC,
   parameter int C_BACK   = C_DEF_H_BACK,
   parameter int C_WIDTH  = $clog2(C_ACTIVE + C_FRONT + C_SYNC + C_BACK)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               step,
   output logic [C_WIDTH-1:0] count,
   output logic               active,
   output logic               sync
);

   localparam logic [C_WIDTH-1:0] END_ACTIVE = C_WIDTH'(C_ACTIVE - 1);
   localparam logic [C_WIDTH-1:0] END_FRONT  = C_WIDTH'(C_ACTIVE + C_FRONT - 1);
   localparam logic [C_WIDTH-1:0] END_SYNC   = C_WIDTH'(C_ACTIVE + C_FRONT + C_SYNC - 1);
   localparam logic [C_WIDTH-1:0] END_BACK   = C_WIDTH'(C_ACTIVE + C_FRONT + C_SYNC + C_BACK - 1);

   phase_t             state;
   phase_t             state_next;
   logic [C_WIDTH-1:0] count_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         state <= PH_ACTIVE;
      end else if (step) begin
         count <= count_next;
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count + C_WIDTH'(1);
      case (state)
         PH_ACTIVE: if (count == END_ACTIVE) state_next = PH_FRONT;
         PH_FRONT:  if (count == END_FRONT)  state_next = PH_SYNC;
         PH_SYNC:   if (count == END_SYNC)   state_next = PH_BACK;
         PH_BACK:   if (count == END_BACK)   state_next = PH_ACTIVE;
         default:   state_next = PH_ACTIVE;
      endcase
      if (count == END_BACK) count_next = '0;
      active = (state == PH_ACTIVE);
      sync   = (state == PH_SYNC);
   end

endmodule

// File: rtl/vga_pattern_source.sv
// vga_pattern_source
//   VGA test-pattern generator: colour bars, greyscale ramp, 8x8 checkerboard
//   or solid black, with registered syncs, output_enable and frame_start.
//   Ports:
//     pixel_clk      in   pixel clock
//     rst            in   synchronous active-high reset
//     ce             in   pixel clock enable; everything holds when low
//     pattern_sel    in   pattern choice, taken at the start of each frame
//     red/green/blue out  pixel colour, zero outside active video
//     hsync, vsync   out  sync pulses at C_HSYNC_POL / C_VSYNC_POL level
//     output_enable  out  active video
//     frame_start    out  one-cycle pulse with pixel (0,0)
//   All outputs are registered one cycle after the counter state.
module vga_pattern_source
   import vga_pattern_source_pkg::*;
#(
   parameter int C_COMPONENT_DEPTH = C_DEF_COMPONENT_DEPTH,
   parameter int C_H_ACTIVE        = C_DEF_H_ACTIVE,
   parameter int C_H_FRONT         = C_DEF_H_FRONT,
   parameter int C_H_SYNC          = C_DEF_H_SYNC,
   parameter int C_H_BACK          = C_DEF_H_BACK,
   parameter int C_V_ACTIVE        = C_DEF_V_ACTIVE,
   parameter int C_V_FRONT         = C_DEF_V_FRONT,
   parameter int C_V_SYNC          = C_DEF_V_SYNC,
   parameter int C_V_BACK          = C_DEF_V_BACK,
   parameter int C_HSYNC_POL       = 0,
   parameter int C_VSYNC_POL       = 0
) (
   input  logic                         pixel_clk,
   input  logic                         rst,
   input  logic                         ce,
   input  logic [1:0]                   pattern_sel,
   output logic [C_COMPONENT_DEPTH-1:0] red,
   output logic [C_COMPONENT_DEPTH-1:0] green,
   output logic [C_COMPONENT_DEPTH-1:0] blue,
   output logic                         hsync,
   output logic                         vsync,
   output logic                         output_enable,
   output logic                         frame_start
);

   localparam int H_TOTAL   = C_H_ACTIVE + C_H_FRONT + C_H_SYNC + C_H_BACK;
   localparam int V_TOTAL   = C_V_ACTIVE + C_V_FRONT + C_V_SYNC + C_V_BACK;
   localparam int HW        = $clog2(H_TOTAL);
   localparam int VW        = $clog2(V_TOTAL);
   localparam int BAR_WIDTH = C_H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic          HSYNC_ON = (C_HSYNC_POL != 0);
   localparam logic          VSYNC_ON = (C_VSYNC_POL != 0);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_active, h_sync, v_active, v_sync;
   logic          h_wrap, origin, video;

   pattern_t pattern_latched;
   pattern_t pattern_now;

   logic [2:0]                   bar_idx;
   logic [2:0]                   bar_rgb;
   logic [C_COMPONENT_DEPTH-1:0] ramp;
   logic [C_COMPONENT_DEPTH-1:0] pix_r, pix_g, pix_b;

   vga_timing_counter #(
      .C_ACTIVE (C_H_ACTIVE),
      .C_FRONT  (C_H_FRONT),
      .C_SYNC   (C_H_SYNC),
      .C_BACK   (C_H_BACK),
      .C_WIDTH  (HW)
   ) u_h_counter (
      .clk    (pixel_clk),
      .rst    (rst),
      .step   (ce),
      .count  (h),
      .active (h_active),
      .sync   (h_sync)
   );

   vga_timing_counter #(
      .C_ACTIVE (C_V_ACTIVE),
      .C_FRONT  (C_V_FRONT),
      .C_SYNC   (C_V_SYNC),
      .C_BACK   (C_V_BACK),
      .C_WIDTH  (VW)
   ) u_v_counter (
      .clk    (pixel_clk),
      .rst    (rst),
      .step   (h_wrap),
      .count  (v),
      .active (v_active),
      .sync   (v_sync)
   );

   // The frame's first pixel already uses the freshly sampled pattern_sel;
   // the latch carries that choice through the rest of the frame.
   always_comb begin
      h_wrap      = ce && (h == H_LAST);
      origin      = (h == '0) && (v == '0);
      video       = h_active && v_active;
      pattern_now = origin ? pattern_t'(pattern_sel) : pattern_latched;
   end

   always_comb begin
      bar_idx = 3'(h / BAR_WIDTH);
      bar_rgb = bar_colour(bar_idx);
      ramp    = C_COMPONENT_DEPTH'(h);
      pix_r   = '0;
      pix_g   = '0;
      pix_b   = '0;
      if (video) begin
         case (pattern_now)
            PAT_BARS: begin
               pix_r = {C_COMPONENT_DEPTH{bar_rgb[2]}};
               pix_g = {C_COMPONENT_DEPTH{bar_rgb[1]}};
               pix_b = {C_COMPONENT_DEPTH{bar_rgb[0]}};
            end
            PAT_RAMP: begin
               pix_r = ramp;
               pix_g = ramp;
               pix_b = ramp;
            end
            PAT_CHECKER: begin
               if (h[3] ^ v[3]) begin
                  pix_r = '1;
                  pix_g = '1;
                  pix_b = '1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         red             <= '0;
         green           <= '0;
         blue            <= '0;
         hsync           <= ~HSYNC_ON;
         vsync           <= ~VSYNC_ON;
         output_enable   <= 1'b0;
         frame_start     <= 1'b0;
         pattern_latched <= PAT_BARS;
      end else if (ce) begin
         red           <= pix_r;
         green         <= pix_g;
         blue          <= pix_b;
         hsync         <= h_sync ? HSYNC_ON : ~HSYNC_ON;
         vsync         <= v_sync ? VSYNC_ON : ~VSYNC_ON;
         output_enable <= video;
         frame_start   <= origin;
         if (origin) pattern_latched <= pattern_t'(pattern_sel);
      end
   end

endmodule

// File: tb/tb_vga_pattern_source.sv
// tb_vga_pattern_source
//   Default-timing instance: table of (pattern, h, v) pixel vectors with
//   hand-computed outputs. Two reduced-timing instances (80x24 total, one with
//   inverted sync polarity) checked cycle by cycle against a behavioural model
//   through frame statistics, a mid-frame pattern switch, ce toggling and a
//   mid-line reset.
module tb_vga_pattern_source;

   localparam int S_HA = 64, S_HF = 4, S_HS = 8, S_HB = 4;
   localparam int S_VA = 16, S_VF = 2, S_VS = 2, S_VB = 4;
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
   localparam int D_HT = 800;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-timing DUT
   logic       d_rst = 1'b0, d_ce = 1'b0;
   logic [1:0] d_sel = 2'd0;
   logic [7:0] d_r, d_g, d_b;
   logic       d_hs, d_vs, d_oe, d_fs;

   // reduced-timing DUTs share inputs
   logic       s_rst = 1'b0, s_ce = 1'b0;
   logic [1:0] s_sel = 2'd0;
   logic [7:0] sm_r, sm_g, sm_b, po_r, po_g, po_b;
   logic       sm_hs, sm_vs, sm_oe, sm_fs, po_hs, po_vs, po_oe, po_fs;

   vga_pattern_source u_dut (
      .pixel_clk (clk), .rst (d_rst), .ce (d_ce), .pattern_sel (d_sel),
      .red (d_r), .green (d_g), .blue (d_b), .hsync (d_hs), .vsync (d_vs),
      .output_enable (d_oe), .frame_start (d_fs)
   );

   vga_pattern_source #(
      .C_H_ACTIVE (S_HA), .C_H_FRONT (S_HF), .C_H_SYNC (S_HS), .C_H_BACK (S_HB),
      .C_V_ACTIVE (S_VA), .C_V_FRONT (S_VF), .C_V_SYNC (S_VS), .C_V_BACK (S_VB)
   ) u_small (
      .pixel_clk (clk), .rst (s_rst), .ce (s_ce), .pattern_sel (s_sel),
      .red (sm_r), .green (sm_g), .blue (sm_b), .hsync (sm_hs), .vsync (sm_vs),
      .output_enable (sm_oe), .frame_start (sm_fs)
   );

   vga_pattern_source #(
      .C_H_ACTIVE (S_HA), .C_H_FRONT (S_HF), .C_H_SYNC (S_HS), .C_H_BACK (S_HB),
      .C_V_ACTIVE (S_VA), .C_V_FRONT (S_VF), .C_V_SYNC (S_VS), .C_V_BACK (S_VB),
      .C_HSYNC_POL (1), .C_VSYNC_POL (1)
   ) u_pol (
      .pixel_clk (clk), .rst (s_rst), .ce (s_ce), .pattern_sel (s_sel),
      .red (po_r), .green (po_g), .blue (po_b), .hsync (po_hs), .vsync (po_vs),
      .output_enable (po_oe), .frame_start (po_fs)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // ---------------- table vectors for the default-timing DUT -------------
   typedef struct {
      logic [1:0]  pat;
      int          h;
      int          v;
      logic [23:0] rgb;
      logic        oe;
      logic        hs;
      logic        vs;
      logic        fs;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [1:0] pat, input int h, input int v,
                               input logic [23:0] rgb, input logic oe,
                               input logic hs, input logic vs, input logic fs);
      vec_t t;
      t.pat = pat; t.h = h; t.v = v; t.rgb = rgb;
      t.oe = oe; t.hs = hs; t.vs = vs; t.fs = fs;
      return t;
   endfunction

   // ---------------- reference model for the reduced-timing DUTs ----------
   // packed as {r, g, b, oe, hsync asserted, vsync asserted, frame_start}
   function automatic logic [27:0] model_px(input logic [1:0] pat, input int h, input int v);
      logic [7:0] c_r, c_g, c_b;
      logic       video;
      int         bar;
      video = (h < S_HA) && (v < S_VA);
      c_r = 8'h00; c_g = 8'h00; c_b = 8'h00;
      if (video) begin
         case (pat)
            2'd0: begin
               bar = h / (S_HA / 8);
               c_r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
               c_g = (bar <= 3) ? 8'hFF : 8'h00;
               c_b = (bar % 2 == 0) ? 8'hFF : 8'h00;
            end
            2'd1: begin
               c_r = 8'(h); c_g = 8'(h); c_b = 8'(h);
            end
            2'd2: begin
               if (((h / 8) + (v / 8)) % 2 == 1) begin
                  c_r = 8'hFF; c_g = 8'hFF; c_b = 8'hFF;
               end
            end
            default: ;
         endcase
      end
      return {c_r, c_g, c_b, video,
              (h >= S_HA + S_HF) && (h < S_HA + S_HF + S_HS),
              (v >= S_VA + S_VF) && (v < S_VA + S_VF + S_VS),
              (h == 0) && (v == 0)};
   endfunction

   int          mh = 0, mv = 0, ph = -1, pv = -1;
   logic [1:0]  mlat = 2'd0;
   logic [27:0] exp_px = '0;
   logic        trace_on = 1'b0;
   int          trace_err = 0;

   // One clock for everything; advances the model from the current inputs,
   // then samples 1 ns after the edge.
   task automatic tick();
      logic [1:0] eff;
      if (s_rst) begin
         mh = 0; mv = 0; mlat = 2'd0; exp_px = '0; ph = -1; pv = -1;
      end else if (s_ce) begin
         eff = (mh == 0 && mv == 0) ? s_sel : mlat;
         if (mh == 0 && mv == 0) mlat = s_sel;
         exp_px = model_px(eff, mh, mv);
         ph = mh; pv = mv;
         mh++;
         if (mh == S_HT) begin
            mh = 0; mv++;
            if (mv == S_VT) mv = 0;
         end
      end
      @(posedge clk);
      #1;
      if (trace_on) begin
         if ({sm_r, sm_g, sm_b, sm_oe, ~sm_hs, ~sm_vs, sm_fs} !== exp_px) trace_err++;
         if ({po_r, po_g, po_b, po_oe, po_hs, po_vs, po_fs} !== exp_px) trace_err++;
      end
   endtask

   initial begin
      int fs_cnt, hs_cyc, hs_pulse, vs_cyc, vs_pulse, oe_cnt, pol_hs, pol_vs;
      logic prev_hs, prev_vs;

      // ---- reset state of the default DUT (rst wins over ce) ----
      d_rst = 1'b1; d_ce = 1'b1;
      tick();
      check("rst_rgb", {d_r, d_g, d_b}, 24'h0);
      check("rst_oe",  d_oe, 1'b0);
      check("rst_fs",  d_fs, 1'b0);
      check("rst_hs",  d_hs, 1'b1);
      check("rst_vs",  d_vs, 1'b1);

      // ---- table vectors at default timing ----
      vecs.push_back(mk(2'd0,   0, 0, 24'hFFFFFF, 1, 1, 1, 1));
      vecs.push_back(mk(2'd0,  80, 0, 24'hFFFF00, 1, 1, 1, 0));
      vecs.push_back(mk(2'd0, 399, 0, 24'hFF00FF, 1, 1, 1, 0));
      vecs.push_back(mk(2'd0, 400, 0, 24'hFF0000, 1, 1, 1, 0));
      vecs.push_back(mk(2'd0, 639, 0, 24'h000000, 1, 1, 1, 0));
      vecs.push_back(mk(2'd0, 640, 0, 24'h000000, 0, 1, 1, 0));
      vecs.push_back(mk(2'd0, 656, 0, 24'h000000, 0, 0, 1, 0));
      vecs.push_back(mk(2'd0, 751, 0, 24'h000000, 0, 0, 1, 0));
      vecs.push_back(mk(2'd0, 752, 0, 24'h000000, 0, 1, 1, 0));
      vecs.push_back(mk(2'd2,   8, 0, 24'hFFFFFF, 1, 1, 1, 0));
      vecs.push_back(mk(2'd2,   8, 8, 24'h000000, 1, 1, 1, 0));
      vecs.push_back(mk(2'd2,   0, 8, 24'hFFFFFF, 1, 1, 1, 0));
      vecs.push_back(mk(2'd2, 700, 3, 24'h000000, 0, 0, 1, 0));
      vecs.push_back(mk(2'd1,  37, 0, 24'h252525, 1, 1, 1, 0));
      vecs.push_back(mk(2'd1, 300, 2, 24'h2C2C2C, 1, 1, 1, 0));
      vecs.push_back(mk(2'd3, 100, 5, 24'h000000, 1, 1, 1, 0));

      foreach (vecs[i]) begin
         d_rst = 1'b1; d_ce = 1'b1; d_sel = vecs[i].pat;
         tick();
         d_rst = 1'b0;
         for (int n = 0; n < vecs[i].v * D_HT + vecs[i].h + 1; n++) tick();
         check($sformatf("vec%0d_rgb", i), {d_r, d_g, d_b}, vecs[i].rgb);
         check($sformatf("vec%0d_oe", i),  d_oe, vecs[i].oe);
         check($sformatf("vec%0d_hs", i),  d_hs, vecs[i].hs);
         check($sformatf("vec%0d_vs", i),  d_vs, vecs[i].vs);
         check($sformatf("vec%0d_fs", i),  d_fs, vecs[i].fs);
      end
      d_ce = 1'b0;

      // ---- reduced timing: reset, then one whole frame of statistics ----
      s_rst = 1'b1; s_ce = 1'b1; s_sel = 2'd0;
      tick();
      check("s_rst_rgb", {sm_r, sm_g, sm_b}, 24'h0);
      check("s_rst_syncs", {sm_hs, sm_vs, sm_oe, sm_fs}, 4'b1100);
      check("pol_rst_syncs", {po_hs, po_vs, po_oe, po_fs}, 4'b0000);
      trace_on = 1'b1;
      s_rst = 1'b0;
      fs_cnt = 0; hs_cyc = 0; hs_pulse = 0; vs_cyc = 0; vs_pulse = 0;
      oe_cnt = 0; pol_hs = 0; pol_vs = 0;
      prev_hs = 1'b1; prev_vs = 1'b1;
      for (int i = 0; i < S_HT * S_VT; i++) begin
         tick();
         if (i == 0) check("first_fs", sm_fs, 1'b1);
         if (sm_fs) fs_cnt++;
         if (!sm_hs) hs_cyc++;
         if (prev_hs && !sm_hs) hs_pulse++;
         if (!sm_vs) vs_cyc++;
         if (prev_vs && !sm_vs) vs_pulse++;
         if (sm_oe) oe_cnt++;
         if (po_hs) pol_hs++;
         if (po_vs) pol_vs++;
         prev_hs = sm_hs; prev_vs = sm_vs;
      end
      check("frame_starts",  fs_cnt, 1);
      check("hsync_cycles",  hs_cyc, S_HS * S_VT);
      check("hsync_pulses",  hs_pulse, S_VT);
      check("vsync_cycles",  vs_cyc, S_VS * S_HT);
      check("vsync_pulses",  vs_pulse, 1);
      check("oe_cycles",     oe_cnt, S_HA * S_VA);
      check("pol_hs_cycles", pol_hs, S_HS * S_VT);
      check("pol_vs_cycles", pol_vs, S_VS * S_HT);
      check("trace_frame",   trace_err, 0);
      trace_err = 0;

      // ---- pattern_sel 0 -> 1 at line 10: takes effect next frame ----
      for (int i = 0; i < S_HT * 10; i++) tick();
      s_sel = 2'd1;
      for (int i = 0; i < S_HT * (S_VT - 10) + 38; i++) begin
         tick();
         if (ph == 37 && pv == 12) check("switch_same_frame", {sm_r, sm_g, sm_b}, 24'hFF00FF);
         if (ph == 37 && pv == 0)  check("switch_next_frame", {sm_r, sm_g, sm_b}, 24'h252525);
      end
      check("trace_switch", trace_err, 0);
      trace_err = 0;

      // ---- ce toggling 1010...: values held for the idle cycle ----
      for (int i = 0; i < 200; i++) begin
         s_ce = (i % 2 == 0);
         tick();
      end
      s_ce = 1'b1;
      check("trace_ce_toggle", trace_err, 0);
      trace_err = 0;

      // ---- reset mid-line at (30,12), with ce low during reset ----
      for (int i = 0; i < 2 * S_HT * S_VT && !(ph == 30 && pv == 12); i++) tick();
      check("reach_30_12", (ph == 30 && pv == 12), 1'b1);
      s_rst = 1'b1; s_ce = 1'b0;
      tick();
      check("mid_rst_rgb", {sm_r, sm_g, sm_b}, 24'h0);
      check("mid_rst_syncs", {sm_hs, sm_vs, sm_oe, sm_fs}, 4'b1100);
      check("mid_rst_pol", {po_hs, po_vs}, 2'b00);
      s_rst = 1'b0;
      tick();
      check("post_rst_idle_fs", sm_fs, 1'b0);
      s_ce = 1'b1; s_sel = 2'd0;
      tick();
      check("post_rst_fs", sm_fs, 1'b1);
      check("post_rst_px", {sm_r, sm_g, sm_b, sm_oe}, {24'hFFFFFF, 1'b1});
      for (int i = 0; i < 100; i++) tick();
      check("trace_after_rst", trace_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
